// File: rtl/iob_bus_merge2.sv
// Two-into-one IOb native bus merger: round-robin arbitration with grant hold,
// a single outstanding read and a read-response watchdog with a sticky timeout flag.
module iob_bus_merge2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TO_W   = 8,
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W = DATA_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  i_req,
  output logic [RESP_W-1:0] i_resp,
  input  logic [REQ_W-1:0]  d_req,
  output logic [RESP_W-1:0] d_resp,
  output logic [REQ_W-1:0]  m_req,
  input  logic [RESP_W-1:0] m_resp,
  output logic              timeout
);

  typedef enum logic [1:0] {IDLE, HOLD, RD_WAIT} state_t;

  state_t          state;
  logic            last_winner;
  logic            owner;
  logic [TO_W-1:0] wd;

  logic              i_valid, d_valid;
  logic              grant, gnt_valid;
  logic              m_ready, m_rvalid;
  logic [DATA_W-1:0] m_rdata, rd_data;
  logic [REQ_W-1:0]  gnt_req;
  logic              is_read, accept;
  logic              wd_max, rd_done;
  logic              i_rd, d_rd;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    i_valid   = i_req[REQ_W-1];
    d_valid   = d_req[REQ_W-1];
    m_ready   = m_resp[0];
    m_rvalid  = m_resp[1];
    m_rdata   = m_resp[RESP_W-1:2];
    grant     = owner;
    gnt_valid = 1'b0;

    case (state)
      IDLE: begin
        // A tie goes to whoever did not win last; a lone requester always wins.
        grant     = (i_valid && d_valid) ? ~last_winner : d_valid;
        gnt_valid = i_valid | d_valid;
      end
      HOLD: begin
        grant     = owner;
        gnt_valid = owner ? d_valid : i_valid;
      end
      default: ;
    endcase

    if (rst) gnt_valid = 1'b0;

    gnt_req = grant ? d_req : i_req;
    is_read = (gnt_req[DATA_W/8-1:0] == '0);
    accept  = gnt_valid & m_ready;
    m_req   = gnt_valid ? gnt_req : '0;

    // Watchdog expiry completes the read with zero data; a real rvalid wins a tie.
    wd_max  = &wd;
    rd_done = !rst && (state == RD_WAIT) && (m_rvalid || wd_max);
    rd_data = m_rvalid ? m_rdata : '0;
    i_rd    = rd_done & ~owner;
    d_rd    = rd_done & owner;

    i_resp = {i_rd ? rd_data : {DATA_W{1'b0}}, i_rd, accept & ~grant};
    d_resp = {d_rd ? rd_data : {DATA_W{1'b0}}, d_rd, accept & grant};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= 1'b0;
      owner       <= 1'b0;
      wd          <= '0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (!gnt_valid) begin
            state <= IDLE;
          end else if (m_ready) begin
            last_winner <= grant;
            if (is_read) begin
              state <= RD_WAIT;
              owner <= grant;
              wd    <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= HOLD;
            owner <= grant;
          end
        end
        RD_WAIT: begin
          wd <= wd + 1'b1;
          if (m_rvalid) begin
            state <= IDLE;
          end else if (wd_max) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
